// File: rtl/ycbcr2bin_adapt_pkg.sv
// Shared constants and pixel helpers for the adaptive binarizer.
// Helpers work at the widest legal pixel width; callers size-cast.
package ycbcr2bin_adapt_pkg;

  localparam int DW_DEF     = 8;
  localparam int THRESH_DEF = 125;
  localparam int HYST_DEF   = 4;
  localparam int MAXW       = 12;

  function automatic logic [MAXW-1:0] px_min(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic [MAXW-1:0] px_max(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Sum carried one bit wider so the midpoint never overflows.
  function automatic logic [MAXW-1:0] px_mid(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b
  );
    logic [MAXW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[MAXW:1];
  endfunction

endpackage

// File: rtl/ycbcr2bin_adapt_frame_minmax_stat.sv
// Per-frame luma min/max tracker with midpoint latch (auto threshold).
// Ports: clk, rst_n, start_i (frame start), de_i, y_i, auto_thr_o.
module frame_minmax_stat
  import ycbcr2bin_adapt_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int THRESH_INIT = THRESH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          de_i,
  input  logic [DW-1:0] y_i,
  output logic [DW-1:0] auto_thr_o
);

  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] INIT = DW'(THRESH_INIT);

  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] auto_q, auto_d;
  logic          seen_q, seen_d;

  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    auto_d = auto_q;
    seen_d = seen_q;
    if (start_i) begin
      if (seen_q)
        auto_d = DW'(px_mid(MAXW'(min_q),
                            MAXW'(max_q)));
      // A pixel on the start cycle opens the new frame.
      min_d  = de_i ? y_i : ONES;
      max_d  = de_i ? y_i : '0;
      seen_d = de_i;
    end else if (de_i) begin
      min_d  = DW'(px_min(MAXW'(min_q),
                          MAXW'(y_i)));
      max_d  = DW'(px_max(MAXW'(max_q),
                          MAXW'(y_i)));
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q  <= ONES;
      max_q  <= '0;
      auto_q <= INIT;
      seen_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      auto_q <= auto_d;
      seen_q <= seen_d;
    end
  end

  assign auto_thr_o = auto_q;

endmodule

// File: rtl/ycbcr2bin_adapt.sv
// Adaptive luma binarizer, 2-clock latency, threshold fixed per frame.
// Ports: clk, rst_n, pre_frame_* / img_y in; post_frame_* / img_bin,
// thresh_cur out; thresh_cfg, mode_auto, invert latched at frame start.
// Optional hysteresis compiled in with macro BIN_HYST_EN.
module ycbcr2bin_adapt
  import ycbcr2bin_adapt_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int THRESH_INIT = THRESH_DEF,
  parameter int HYST        = HYST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pre_frame_vsync,
  input  logic          pre_frame_hsync,
  input  logic          pre_frame_de,
  input  logic [DW-1:0] img_y,
  input  logic [DW-1:0] thresh_cfg,
  input  logic          mode_auto,
  input  logic          invert,
  output logic          post_frame_vsync,
  output logic          post_frame_hsync,
  output logic          post_frame_de,
  output logic [DW-1:0] img_bin,
  output logic [DW-1:0] thresh_cur
);

  localparam logic [DW-1:0] INIT = DW'(THRESH_INIT);

  logic [DW-1:0] y1_q;
  logic          de1_q, hs1_q, vs1_q;
  logic          de2_q, hs2_q, vs2_q;
  logic [DW-1:0] bin_q, bin_d;

  logic          mode_q, inv_q, start_q;
  logic [DW-1:0] cfg_q;
  logic [DW-1:0] thr_q, thr_d, thr_nxt, thr_eff;
  logic [DW-1:0] auto_thr;
  logic          vs_rise, raw;

  assign vs_rise = pre_frame_vsync & ~vs1_q;

  frame_minmax_stat #(
    .DW         (DW),
    .THRESH_INIT(THRESH_INIT)
  ) u_stat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (vs_rise),
    .de_i      (pre_frame_de),
    .y_i       (img_y),
    .auto_thr_o(auto_thr)
  );

  // The start-cycle pixel sits in stage 1 while thr_q loads,
  // so it sees the new frame's threshold through this bypass.
  assign thr_nxt = mode_q ? auto_thr : cfg_q;
  assign thr_eff = start_q ? thr_nxt : thr_q;
  assign thr_d   = thr_eff;

`ifdef BIN_HYST_EN
  logic          prev_q, prev_d, de_rise;
  logic [DW:0]   hi_w;
  logic [DW-1:0] thr_hi, thr_lo;

  assign de_rise = de1_q & ~de2_q;
  assign hi_w    = {1'b0, thr_eff} + (DW+1)'(HYST);
  assign thr_hi  = hi_w[DW] ? '1 : hi_w[DW-1:0];
  assign thr_lo  = (thr_eff < DW'(HYST)) ?
                   '0 : thr_eff - DW'(HYST);

  always_comb begin
    raw = 1'b0;
    if (y1_q > thr_hi)
      raw = 1'b1;
    else if (y1_q < thr_lo)
      raw = 1'b0;
    else
      raw = de_rise ? 1'b0 : prev_q;
    prev_d = de1_q ? raw : prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end
`else
  always_comb begin
    raw = 1'b0;
    raw = (y1_q > thr_eff);
  end
`endif

  always_comb begin
    bin_d = '0;
    if (de1_q)
      bin_d = {DW{raw ^ inv_q}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_q  <= '0;
      de1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      de2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      bin_q <= '0;
    end else begin
      y1_q  <= img_y;
      de1_q <= pre_frame_de;
      hs1_q <= pre_frame_hsync;
      vs1_q <= pre_frame_vsync;
      de2_q <= de1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      bin_q <= bin_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      inv_q   <= 1'b0;
      cfg_q   <= INIT;
      start_q <= 1'b0;
      thr_q   <= INIT;
    end else begin
      start_q <= vs_rise;
      thr_q   <= thr_d;
      if (vs_rise) begin
        mode_q <= mode_auto;
        inv_q  <= invert;
        cfg_q  <= thresh_cfg;
      end
    end
  end

  assign post_frame_vsync = vs2_q;
  assign post_frame_hsync = hs2_q;
  assign post_frame_de    = de2_q;
  assign img_bin          = bin_q;
  assign thresh_cur       = thr_q;

endmodule

// File: tb/tb_ycbcr2bin_adapt.sv
// Scoreboard bench for ycbcr2bin_adapt (DW=8, THRESH_INIT=125).
// Directed frames; expected pixels queued at drive, popped by a monitor.
module tb_ycbcr2bin_adapt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs, hs, de;
  logic [7:0] y, cfg;
  logic       mode, inv;
  logic       o_vs, o_hs, o_de;
  logic [7:0] o_bin, o_thr;

  typedef struct {
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] bin;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ycbcr2bin_adapt dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pre_frame_vsync (vs),
    .pre_frame_hsync (hs),
    .pre_frame_de    (de),
    .img_y           (y),
    .thresh_cfg      (cfg),
    .mode_auto       (mode),
    .invert          (inv),
    .post_frame_vsync(o_vs),
    .post_frame_hsync(o_hs),
    .post_frame_de   (o_de),
    .img_bin         (o_bin),
    .thresh_cur      (o_thr)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  // One input cycle; result due two clocks later.
  task automatic drv(input logic v, input logic h,
                     input logic d, input logic [7:0] py,
                     input logic [7:0] eb);
    exp_t e;
    vs = v; hs = h; de = d; y = py;
    e.vs = v; e.hs = h; e.de = d;
    e.bin = eb; e.due = cyc + 2;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].due < cyc) begin
        chk("stale_entry", q[0].due, cyc);
        void'(q.pop_front());
      end else if (q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("post_vsync", o_vs, e.vs);
        chk("post_hsync", o_hs, e.hs);
        chk("post_de", o_de, e.de);
        chk("img_bin", o_bin, e.bin);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    vs = 0; hs = 0; de = 0; y = 8'd0;
    cfg = 8'd125; mode = 0; inv = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin", o_bin, 0);
    chk("rst_de", o_de, 0);
    chk("rst_vs", o_vs, 0);
    chk("rst_hs", o_hs, 0);
    chk("rst_thr", o_thr, 125);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifndef BIN_HYST_EN
    // Frame A: fixed 125, boundary, invert change ignored mid-frame
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    drv(0, 1, 1, 8'd125, 8'd0);
    drv(0, 1, 1, 8'd126, 8'd255);
    inv = 1;
    drv(0, 1, 1, 8'd200, 8'd255);
    drv(0, 0, 0, 8'd200, 8'd0);
    chk("thr_A", o_thr, 125);
    // Frame B: invert latched
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 1, 8'd200, 8'd0);
    drv(0, 0, 1, 8'd100, 8'd255);
    drv(0, 0, 0, 8'd200, 8'd0);
    drv(0, 0, 0, 8'd50, 8'd0);
    chk("thr_B", o_thr, 125);
    inv = 0; mode = 1;
    // Frame C: auto from B {200,100} = 150
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_C", o_thr, 150);
    drv(0, 1, 1, 8'd40, 8'd0);
    drv(0, 1, 1, 8'd90, 8'd0);
    drv(0, 1, 1, 8'd200, 8'd255);
    drv(0, 0, 0, 8'd0, 8'd0);
    // Frame D: auto {40,90,200} = 120
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_D", o_thr, 120);
    drv(0, 1, 1, 8'd121, 8'd255);
    drv(0, 1, 1, 8'd120, 8'd0);
    mode = 0; cfg = 8'd50;
    drv(0, 1, 1, 8'd100, 8'd0);
    chk("thr_D_mid", o_thr, 120);
    mode = 1; cfg = 8'd125;
    drv(0, 0, 0, 8'd0, 8'd0);
    // Frame E: auto {121,120,100} = 110
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_E", o_thr, 110);
    drv(0, 1, 1, 8'd10, 8'd0);
    drv(0, 1, 1, 8'd30, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    // Frame F: auto {10,30} = 20, no pixels
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_F", o_thr, 20);
    drv(0, 0, 0, 8'd90, 8'd0);
    // Frame G: empty F keeps 20
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_G", o_thr, 20);
    drv(0, 1, 1, 8'd21, 8'd255);
    drv(0, 1, 1, 8'd20, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    // Frame H: auto {21,20} = 20; single value 77
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    drv(0, 1, 1, 8'd77, 8'd255);
    drv(0, 1, 1, 8'd77, 8'd255);
    drv(0, 0, 0, 8'd0, 8'd0);
    // Frame I: auto = 77; pixel on vsync edge counts
    drv(1, 0, 1, 8'd250, 8'd255);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_I", o_thr, 77);
    drv(0, 1, 1, 8'd78, 8'd255);
    drv(0, 0, 0, 8'd0, 8'd0);
    // Frame J: auto {250,78} = 164
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_J", o_thr, 164);
    drv(0, 1, 1, 8'd165, 8'd255);
    drv(0, 1, 1, 8'd164, 8'd0);
    drv(0, 1, 1, 8'd255, 8'd255);
    drv(0, 1, 1, 8'd0, 8'd0);
`else
    // Hysteresis: thr 100, band 96..104
    mode = 0; cfg = 8'd100;
    drv(1, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    chk("thr_hyst", o_thr, 100);
    drv(0, 1, 1, 8'd110, 8'd255);
    drv(0, 1, 1, 8'd98, 8'd255);
    drv(0, 1, 1, 8'd103, 8'd255);
    drv(0, 1, 1, 8'd95, 8'd0);
    drv(0, 1, 1, 8'd102, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    drv(0, 1, 1, 8'd110, 8'd255);
    drv(0, 0, 0, 8'd0, 8'd0);
    drv(0, 1, 1, 8'd102, 8'd0);
`endif
    drv(0, 0, 0, 8'd0, 8'd0);
    drv(0, 0, 0, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
